wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter NUM, default 32: register count; register index width is clog2(NUM).
REQ-003 SHALL have port clock, in, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, in, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports alu_valid (in, 1), alu_rd (in, idx), alu_data (in, WIDTH): single-cycle ALU result; cannot be stalled.
REQ-006 SHALL have ports ld_issue (in, 1) and ld_issue_rd (in, idx): a load has been issued to destination ld_issue_rd.
REQ-007 SHALL have ports ld_valid (in, 1), ld_rd (in, idx), ld_data (in, WIDTH) and ld_ready (out, 1): load-return valid/ready handshake.
REQ-008 SHALL have ports rs1 and rs2 (in, idx): source indices of the instruction being decoded.
REQ-009 SHALL have port stall (out, 1): decode must hold.
REQ-010 SHALL have ports address_w (out, idx) and data_w (out, WIDTH): regfile write port; address 0 means no write.
REQ-011 SHALL have ports byp1_hit/byp2_hit (out, 1) and byp1_data/byp2_data (out, WIDTH): forwarding of the in-flight write.

Function
REQ-012 SHALL register the selected result into address_w/data_w, giving 1-cycle latency from acceptance to regfile write.
REQ-013 SHALL give the ALU priority: when alu_valid and alu_rd!=0, it is selected and ld_ready=0.
REQ-014 SHALL assert ld_ready=1 whenever REQ-013 does not apply; a load transfers on ld_valid&&ld_ready.
REQ-015 SHALL drive address_w=0 in the cycle after a cycle with no transfer; data_w then holds its last value.
REQ-016 SHALL treat writes to index 0 as discarded: no pending-bit change and address_w=0.
REQ-017 SHALL keep a pending bit per register: set on ld_issue (ld_issue_rd!=0), cleared on load transfer to ld_rd.
REQ-018 SHALL, when set and clear target the same index in the same cycle, leave the bit set.
REQ-019 SHALL assert stall when pending[rs1] or pending[rs2] is set (index 0 excluded), and when ld_issue occurs while pending[ld_issue_rd] is already set (WAW).
REQ-020 SHALL compute stall and ld_ready combinationally from current inputs and state.

Reset
REQ-021 SHALL, on clock edge with reset_n=0: address_w=0, data_w=0, all pending bits=0.
REQ-022 SHALL discard any in-flight result on reset mid-operation; loads outstanding at reset are forgotten.

Configuration
REQ-023 SHALL use macro WB_BYPASS_EN. Defined: byp*_hit=1 when address_w!=0 and address_w equals rs1/rs2, with byp*_data=data_w. Not defined: byp*_hit=0, byp*_data=0, and stall is additionally asserted on that same match.

Structure
REQ-024 SHALL place the index-width constant and the default WIDTH/NUM in the shared package.
REQ-025 SHALL implement the pending-bit array as the sub-module wb_scoreboard: set/clear/query ports, x0 hardwired clear.

Verification
REQ-026 SHALL cover: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle address_w=5, data_w=0x1234.
REQ-027 SHALL cover: ld_issue rd=7, then rs1=7 -> stall=1 until a ld_valid rd=7 transfer; stall=0 the cycle after.
REQ-028 SHALL cover: alu_valid rd=3 and ld_valid rd=4 together -> ld_ready=0, ALU written first, load written on the following cycle.
REQ-029 SHALL cover: ld_issue rd=9 coinciding with a load return to rd=9 -> pending[9] stays set.
REQ-030 SHALL cover: address_w=6 in flight with rs2=6 -> WB_BYPASS_EN: byp2_hit=1, stall=0; without: stall=1.
REQ-031 SHALL cover: reset_n=0 while pending set and a write is in flight -> address_w=0, data_w=0, stall=0 afterwards.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants and types for the write-back stage slice.
//   WB_DEFAULT_WIDTH / WB_DEFAULT_NUM : default data width and register count
//   idx_w()                           : register index width for a given count
//   WB_DEFAULT_IDX_W                  : index width for the default count
//   wb_src_e                          : which source owns the write port
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int WB_DEFAULT_WIDTH = 32;
  localparam int WB_DEFAULT_NUM   = 32;

  // A single-register file still needs a one-bit index.
  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int WB_DEFAULT_IDX_W = idx_w(WB_DEFAULT_NUM);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// One pending bit per architectural register, tracking loads that have been
// issued but whose data has not yet come back. Register 0 is hardwired clear.
//   clock, reset_n     : clock and synchronous active-low reset
//   set_en, set_idx    : mark a register pending (load issued)
//   clr_en, clr_idx    : clear a register's pending bit (load returned)
//   q1/q2/q3_idx       : query indices
//   q1/q2/q3_pend      : pending state of the queried registers
// When set and clear hit the same register in one cycle the set wins: the
// returning load belongs to the older issue, the new issue is still owed.
// -----------------------------------------------------------------------------
module wb_scoreboard
  import wb_stage_pkg::*;
#(
  parameter int NUM = WB_DEFAULT_NUM,
  localparam int IW = idx_w(NUM)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] q1_idx,
  input  logic [IW-1:0] q2_idx,
  input  logic [IW-1:0] q3_idx,
  output logic          q1_pend,
  output logic          q2_pend,
  output logic          q3_pend
);

  logic [NUM-1:0] pend_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_reg[gi] = 1'b0;
      end else begin : g_bit
        always_ff @(posedge clock) begin
          if (!reset_n) begin
            pend_reg[gi] <= 1'b0;
          end else if (set_en && (set_idx == IW'(gi))) begin
            pend_reg[gi] <= 1'b1;
          end else if (clr_en && (clr_idx == IW'(gi))) begin
            pend_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign q1_pend = pend_reg[q1_idx];
  assign q2_pend = pend_reg[q2_idx];
  assign q3_pend = pend_reg[q3_idx];

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back arbiter between a non-stallable ALU result and a load-return
// handshake, with a load scoreboard that generates decode stalls.
//   clock, reset_n                 : clock, synchronous active-low reset
//   alu_valid, alu_rd, alu_data    : single-cycle ALU result (highest priority)
//   ld_issue, ld_issue_rd          : a load was issued to ld_issue_rd
//   ld_valid, ld_rd, ld_data       : load return, accepted when ld_ready=1
//   ld_ready                       : load return may transfer this cycle
//   rs1, rs2                       : source indices of the decoding instruction
//   stall                          : decode must hold
//   address_w, data_w              : registered regfile write (address 0 = none)
//   byp1/2_hit, byp1/2_data        : forwarding of the in-flight write
// Build option: define WB_BYPASS_EN to forward the in-flight write to rs1/rs2.
// Without it the forwarding outputs are tied to zero and a source that
// matches the in-flight write stalls decode for that cycle instead.
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WIDTH = WB_DEFAULT_WIDTH,
  parameter int NUM   = WB_DEFAULT_NUM,
  localparam int IW   = idx_w(NUM)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [IW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             ld_issue,
  input  logic [IW-1:0]    ld_issue_rd,
  input  logic             ld_valid,
  input  logic [IW-1:0]    ld_rd,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic [IW-1:0]    rs1,
  input  logic [IW-1:0]    rs2,
  output logic             stall,
  output logic [IW-1:0]    address_w,
  output logic [WIDTH-1:0] data_w,
  output logic             byp1_hit,
  output logic             byp2_hit,
  output logic [WIDTH-1:0] byp1_data,
  output logic [WIDTH-1:0] byp2_data
);

  logic             alu_sel;
  logic             ld_xfer;
  wb_src_e          src_next;
  logic [IW-1:0]    addr_w_reg;
  logic [IW-1:0]    addr_w_next;
  logic [WIDTH-1:0] data_w_reg;
  logic [WIDTH-1:0] data_w_next;
  logic             rs1_pend;
  logic             rs2_pend;
  logic             issue_pend;
  logic             raw1_inflight;
  logic             raw2_inflight;

  // An ALU write to x0 is a no-op, so it does not take the port from a load.
  assign alu_sel  = alu_valid && (alu_rd != '0);
  assign ld_ready = !alu_sel;
  assign ld_xfer  = ld_valid && ld_ready;

  always_comb begin
    src_next = SRC_NONE;
    if (alu_sel) begin
      src_next = SRC_ALU;
    end else if (ld_xfer && (ld_rd != '0)) begin
      src_next = SRC_LOAD;
    end
  end

  // Data holds its last value whenever nothing is written.
  always_comb begin
    addr_w_next = '0;
    data_w_next = data_w_reg;
    case (src_next)
      SRC_ALU: begin
        addr_w_next = alu_rd;
        data_w_next = alu_data;
      end
      SRC_LOAD: begin
        addr_w_next = ld_rd;
        data_w_next = ld_data;
      end
      default: begin
        addr_w_next = '0;
        data_w_next = data_w_reg;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_w_reg <= '0;
      data_w_reg <= '0;
    end else begin
      addr_w_reg <= addr_w_next;
      data_w_reg <= data_w_next;
    end
  end

  assign address_w = addr_w_reg;
  assign data_w    = data_w_reg;

  wb_scoreboard #(
    .NUM (NUM)
  ) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (ld_issue && (ld_issue_rd != '0)),
    .set_idx (ld_issue_rd),
    .clr_en  (ld_xfer && (ld_rd != '0)),
    .clr_idx (ld_rd),
    .q1_idx  (rs1),
    .q2_idx  (rs2),
    .q3_idx  (ld_issue_rd),
    .q1_pend (rs1_pend),
    .q2_pend (rs2_pend),
    .q3_pend (issue_pend)
  );

  assign raw1_inflight = (addr_w_reg != '0) && (addr_w_reg == rs1);
  assign raw2_inflight = (addr_w_reg != '0) && (addr_w_reg == rs2);

`ifdef WB_BYPASS_EN
  assign byp1_hit  = raw1_inflight;
  assign byp2_hit  = raw2_inflight;
  assign byp1_data = data_w_reg;
  assign byp2_data = data_w_reg;
  // Scoreboard bit 0 is hardwired clear, so x0 never stalls.
  assign stall = rs1_pend || rs2_pend || (ld_issue && issue_pend);
`else
  assign byp1_hit  = 1'b0;
  assign byp2_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_data = '0;
  assign stall = rs1_pend || rs2_pend || (ld_issue && issue_pend)
              || raw1_inflight || raw2_inflight;
`endif

endmodule
